// File: rtl/adder_4bit_full_adder.sv
// One-bit full adder: the single stage of the ripple-carry chain.
// Purely combinational; the enclosing adder supplies all registering.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the parity of the three inputs.
    // A carry is generated when both operand bits are set,
    // or propagated when exactly one is set and a carry arrives.
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + Cin, plus signed overflow.
// One cycle of latency. out_valid marks a freshly accepted result.
// Sum/Cout/Ovf keep their last result while no new operands are accepted.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    // Carry chain: c[i] is the carry into bit i, and c[WIDTH] is the final carry out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign c[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_ripple
            full_adder u_fa (
                .a    (A[i]),
                .b    (B[i]),
                .cin  (c[i]),
                .s    (s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    // Next-state select: capture a new result on in_valid, otherwise hold.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        out_valid_d = in_valid;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            sum_d  = s;
            cout_d = c[WIDTH];
            // Signed overflow: the carry into the MSB differs from the carry out of it.
            ovf_d  = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments, so every flop
            // samples its _d value from before this edge, whatever the statement order.
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_adder_4bit.sv
// Directed and exhaustive bench for the registered 4-bit adder.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       out_valid;
    logic [3:0] Sum;
    logic       Cout;
    logic       Ovf;

    int total = 0;
    int bad   = 0;

    adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 4'h0;
        B        = 4'h0;
        Cin      = 1'b0;
        step();
        step();
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state: got v=%b c=%b o=%b s=%b, want all 0",
                     out_valid, Cout, Ovf, Sum);
        end
        // Release reset in mid-cycle, away from the clock edge.
        #2 rst_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        // Columns: A, B, Cin, expected Sum, Cout, Ovf.
        logic [3:0] va [5] = '{4'b0000, 4'b0001, 4'b1010, 4'b1111, 4'b0111};
        logic [3:0] vb [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1111, 4'b0001};
        logic       vc [5] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        logic [3:0] es [5] = '{4'b0000, 4'b0011, 4'b1100, 4'b1111, 4'b1000};
        logic       ec [5] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0};
        logic       eo [5] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            A        = va[k];
            B        = vb[k];
            Cin      = vc[k];
            step();
            in_valid = 1'b0;
            total++;
            if ({out_valid, Cout, Ovf, Sum} !== {1'b1, ec[k], eo[k], es[k]}) begin
                bad++;
                $display("FAIL directed_%0d: got v=%b c=%b o=%b s=%b, want v=1 c=%b o=%b s=%b",
                         k, out_valid, Cout, Ovf, Sum, ec[k], eo[k], es[k]);
            end
            step();
        end
    endtask

    // The last directed result was 0111+0001+0 -> Sum=1000, Cout=0, Ovf=1.
    task automatic test_hold();
        in_valid = 1'b0;
        A        = 4'b1111;
        B        = 4'b1111;
        Cin      = 1'b1;
        step();
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== {1'b0, 1'b0, 1'b1, 4'b1000}) begin
            bad++;
            $display("FAIL hold_changed_inputs: got v=%b c=%b o=%b s=%b, want v=0 c=0 o=1 s=1000",
                     out_valid, Cout, Ovf, Sum);
        end
        A   = 4'bxxxx;
        B   = 4'bxxxx;
        Cin = 1'bx;
        step();
        step();
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== {1'b0, 1'b0, 1'b1, 4'b1000}) begin
            bad++;
            $display("FAIL hold_x_inputs: got v=%b c=%b o=%b s=%b, want v=0 c=0 o=1 s=1000",
                     out_valid, Cout, Ovf, Sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3] = '{4'b0011, 4'b1000, 4'b0101};
        logic [3:0] vb [3] = '{4'b0100, 4'b1000, 4'b0101};
        logic       vc [3] = '{1'b1,    1'b0,    1'b0};
        logic [3:0] es [3] = '{4'b1000, 4'b0000, 4'b1010};
        logic       ec [3] = '{1'b0,    1'b1,    1'b0};
        logic       eo [3] = '{1'b1,    1'b1,    1'b1};
        in_valid = 1'b1;
        A        = va[0];
        B        = vb[0];
        Cin      = vc[0];
        for (int k = 0; k < 3; k++) begin
            step();
            if (k < 2) begin
                A   = va[k+1];
                B   = vb[k+1];
                Cin = vc[k+1];
            end else begin
                in_valid = 1'b0;
            end
            total++;
            if ({out_valid, Cout, Ovf, Sum} !== {1'b1, ec[k], eo[k], es[k]}) begin
                bad++;
                $display("FAIL b2b_%0d: got v=%b c=%b o=%b s=%b, want v=1 c=%b o=%b s=%b",
                         k, out_valid, Cout, Ovf, Sum, ec[k], eo[k], es[k]);
            end
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        // 0110 + 0011 = 1001: signed overflow, so the outputs are nonzero before reset.
        in_valid = 1'b1;
        A        = 4'b0110;
        B        = 4'b0011;
        Cin      = 1'b0;
        step();
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== {1'b1, 1'b0, 1'b1, 4'b1001}) begin
            bad++;
            $display("FAIL pre_reset: got v=%b c=%b o=%b s=%b, want v=1 c=0 o=1 s=1001",
                     out_valid, Cout, Ovf, Sum);
        end
        A   = 4'b1111;
        B   = 4'b0001;
        Cin = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset_immediate: got v=%b c=%b o=%b s=%b, want all 0",
                     out_valid, Cout, Ovf, Sum);
        end
        step();
        total++;
        if ({out_valid, Cout, Ovf, Sum} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset_held: got v=%b c=%b o=%b s=%b, want all 0",
                     out_valid, Cout, Ovf, Sum);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_exhaustive();
        logic [3:0] a, b;
        logic       c;
        logic [4:0] full;
        logic       ovf;
        int         errs = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 512; k++) begin
            a    = k[8:5];
            b    = k[4:1];
            c    = k[0];
            A    = a;
            B    = b;
            Cin  = c;
            full = {1'b0, a} + {1'b0, b} + {4'b0, c};
            ovf  = (a[3] == b[3]) && (full[3] != a[3]);
            step();
            total++;
            if ({out_valid, Cout, Ovf, Sum} !== {1'b1, full[4], ovf, full[3:0]}) begin
                bad++;
                errs++;
                if (errs <= 8)
                    $display("FAIL exhaustive a=%b b=%b cin=%b: got v=%b c=%b o=%b s=%b, want v=1 c=%b o=%b s=%b",
                             a, b, c, out_valid, Cout, Ovf, Sum, full[4], ovf, full[3:0]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
